acc_stream_adapter: RTL
=======================

ACC_STREAM_ADAPTER -- requirements
Module: acc_stream_adapter

Interface
REQ-001 Parameter DATA_WIDTH, 32, width of data word.
REQ-002 Parameter DEPTH, 8, FIFO entries; power of two, >=2.
REQ-003 wb_clk_i  input  1  clock; all logic on rising edge.
REQ-004 wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  word-present strobe from the upstream DMA; no backpressure exists.
REQ-006 in_data  input  DATA_WIDTH  word from the upstream DMA, sampled when in_valid=1.
REQ-007 cfg_len_we  input  1  single-cycle strobe loading the frame length.
REQ-008 cfg_len  input  10  frame length in words; 0 is illegal.
REQ-009 clr_i  input  1  synchronous flush and clear.
REQ-010 ss_tvalid  output  1  stream word valid toward the accelerator.
REQ-011 ss_tdata  output  DATA_WIDTH  stream word, equal to the FIFO head.
REQ-012 ss_tlast  output  1  marks the final word of a frame.
REQ-013 ss_tready  input  1  accelerator accepts the word.
REQ-014 level_o  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-015 ovf_o  output  1  sticky overflow flag.
REQ-016 frame_done_o  output  1  one-cycle pulse at frame end.

Function
REQ-017 The FIFO SHALL be first-word-fall-through, with ss_tdata equal to the head entry whenever level_o>0.
REQ-018 A push SHALL occur when in_valid=1 and either the FIFO is not full or a pop occurs in the same cycle.
REQ-019 A pop SHALL occur when ss_tvalid=1 and ss_tready=1.
REQ-020 A simultaneous push and pop SHALL leave level_o unchanged, at any level including 0 with the FIFO in RUN, and including DEPTH.
REQ-021 A word pushed in cycle N SHALL be visible on ss_tvalid/ss_tdata in cycle N+1 at the earliest; no combinational in-to-out path.
REQ-022 A push attempted while full without a pop SHALL drop the word, set ovf_o from the next cycle, and leave FIFO contents unchanged.
REQ-023 ovf_o SHALL stay set until clr_i or reset.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH.
REQ-025 The FSM SHALL have two states: IDLE and RUN.
REQ-026 In IDLE, ss_tvalid SHALL be 0, while input words continue to be buffered.
REQ-027 IDLE SHALL go to RUN when cfg_len_we=1 and cfg_len!=0, loading len_r=cfg_len and clearing the beat counter beat_r=0.
REQ-028 IDLE SHALL ignore cfg_len_we when cfg_len=0.
REQ-029 RUN SHALL ignore cfg_len_we.
REQ-030 In RUN, ss_tvalid SHALL be high when level_o>0.
REQ-031 ss_tlast SHALL be high when ss_tvalid=1 and beat_r==len_r-1.
REQ-032 Each pop in RUN SHALL increment beat_r, which is 10 bits wide.
REQ-033 A pop with ss_tlast=1 SHALL return the FSM to IDLE and pulse frame_done_o for one cycle in the next clock.
REQ-034 ss_tdata and ss_tlast SHALL be held stable while ss_tvalid=1 and ss_tready=0.
REQ-035 clr_i SHALL have priority over all other inputs.
REQ-036 clr_i SHALL empty the FIFO, clear ovf_o, set the FSM to IDLE, and zero beat_r.
REQ-037 A push coincident with clr_i SHALL be discarded.

Reset
REQ-038 Assertion of wb_rst_i SHALL immediately force: FSM IDLE, pointers 0, level_o=0, ss_tvalid=0, ss_tlast=0, ss_tdata=0, ovf_o=0, frame_done_o=0, len_r=0, beat_r=0.
REQ-039 Reset asserted mid-frame SHALL discard buffered data, with no frame_done_o pulse.
REQ-040 Operation SHALL resume on the first rising edge after deassertion.

Verification
REQ-041 Basic frame: cfg_len=4, push 0x11,0x22,0x33,0x44 with ss_tready=1 -> four beats in order, ss_tlast only on 0x44, frame_done_o one pulse, FSM returns to IDLE.
REQ-042 Backpressure: cfg_len=3, ss_tready=0 for 5 cycles after the first word -> ss_tdata holds 0x11, level_o rises to 3, then drains with tlast on the third beat.
REQ-043 Overflow: DEPTH=8, FSM in IDLE, push 9 words -> level_o=8, ninth word dropped, ovf_o=1; a later clr_i gives level_o=0 and ovf_o=0.
REQ-044 Full with simultaneous push/pop: level_o=8 in RUN, ss_tready=1, in_valid=1 -> level_o stays 8, ovf_o stays 0, and the pointers wrap correctly over 20 cycles.
REQ-045 Illegal and in-frame config: cfg_len=0 strobe in IDLE -> stays IDLE; cfg_len=7 strobe mid-frame with len=2 -> tlast still on the second beat.
REQ-046 Reset mid-frame: assert wb_rst_i after 2 of 5 beats -> all outputs 0 immediately, and a new cfg_len=1 frame completes normally.

Source files
------------

// File: rtl/acc_stream_adapter.sv
// ---------------------------------------------------------------------------
// acc_stream_adapter
//
// Bridges a free-running upstream DMA word stream (no backpressure) onto a
// framed valid/ready stream toward an accelerator. Words are buffered in a
// first-word-fall-through FIFO at all times. Words are released to the
// accelerator only while a frame is open. A frame is opened by a length
// strobe and closes after that many beats.
//
// Ports
//   wb_clk_i      clock, rising edge
//   wb_rst_i      asynchronous, active-high reset
//   in_valid      upstream word strobe
//   in_data       upstream word
//   cfg_len_we    frame-length load strobe (honoured only in IDLE)
//   cfg_len       frame length in words (0 is ignored)
//   clr_i         synchronous flush/clear, highest priority
//   ss_tvalid     stream word valid
//   ss_tdata      stream word (FIFO head)
//   ss_tlast      final word of the frame
//   ss_tready     accelerator accepts the word
//   level_o       FIFO occupancy
//   ovf_o         sticky overflow flag
//   frame_done_o  one-cycle pulse after the last beat is accepted
// ---------------------------------------------------------------------------
module acc_stream_adapter #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic                        cfg_len_we,
  input  logic [9:0]                  cfg_len,
  input  logic                        clr_i,
  output logic                        ss_tvalid,
  output logic [DATA_WIDTH-1:0]       ss_tdata,
  output logic                        ss_tlast,
  input  logic                        ss_tready,
  output logic [$clog2(DEPTH):0]      level_o,
  output logic                        ovf_o,
  output logic                        frame_done_o
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0]   LVL_ONE  = 1;
  localparam logic [AW:0]   LVL_FULL = DEPTH;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                state_r;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [AW:0]           level_r;
  logic [9:0]            len_r;
  logic [9:0]            beat_r;
  logic                  ovf_r;
  logic                  frame_done_r;

  logic full;
  logic push;
  logic pop;

  // Outputs are decoded from registered state only, so an incoming word can
  // never reach the stream side in the cycle it arrives.
  assign full      = (level_r == LVL_FULL);
  assign ss_tvalid = (state_r == RUN) && (level_r != '0);
  assign ss_tlast  = ss_tvalid && (beat_r == len_r - 10'd1);
  // Forcing zero while empty makes ss_tdata read 0 straight out of reset
  // even though the storage array itself is never reset.
  assign ss_tdata  = (level_r != '0) ? mem[rd_ptr_r] : '0;

  assign pop  = ss_tvalid && ss_tready;
  // A word arriving while full is still accepted if the head leaves the
  // same cycle; the freed slot is reused immediately.
  assign push = in_valid && (!full || pop);

  assign level_o      = level_r;
  assign ovf_o        = ovf_r;
  assign frame_done_o = frame_done_r;

  // NOTE: storage has no reset; flushing is done by the pointers and level,
  // which keeps the array a plain RAM without a reset fan-out.
  always_ff @(posedge wb_clk_i) begin
    if (!clr_i && push) begin
      mem[wr_ptr_r] <= in_data;
    end
  end

  // NOTE: every register here uses non-blocking assignment, so all state
  // updates see the pre-edge values of push/pop/tlast regardless of order.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r      <= IDLE;
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      level_r      <= '0;
      len_r        <= '0;
      beat_r       <= '0;
      ovf_r        <= 1'b0;
      frame_done_r <= 1'b0;
    end else if (clr_i) begin
      // Flush wins over everything, including a coincident push or pop.
      state_r      <= IDLE;
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      level_r      <= '0;
      beat_r       <= '0;
      ovf_r        <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;

      // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
      if (push) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop)  rd_ptr_r <= rd_ptr_r + PTR_ONE;

      case ({push, pop})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase

      if (in_valid && !push) begin
        ovf_r <= 1'b1;
      end

      case (state_r)
        IDLE: begin
          if (cfg_len_we && (cfg_len != 10'd0)) begin
            state_r <= RUN;
            len_r   <= cfg_len;
            beat_r  <= '0;
          end
        end
        RUN: begin
          if (pop) begin
            beat_r <= beat_r + 10'd1;
            if (ss_tlast) begin
              state_r      <= IDLE;
              frame_done_r <= 1'b1;
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule
